// File: rtl/clock_ctrl_pkg.sv
// Shared widths, limits and state encoding for the clock set controller.
package clock_ctrl_pkg;

  localparam int unsigned SEC_W = 7;
  localparam int unsigned MIN_W = 7;
  localparam int unsigned HR_W  = 5;

  localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
  localparam logic [MIN_W-1:0] MAX_MIN = 7'd59;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HR     = 3'd1,
    SET_MIN    = 3'd2,
    SET_AL_HR  = 3'd3,
    SET_AL_MIN = 3'd4
  } state_e;

  // Hour increment with wrap back to midnight.
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
    return (v >= MAX_HR) ? '0 : v + 1'b1;
  endfunction

  // Minute increment with wrap back to zero.
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
    return (v >= MAX_MIN) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle advance pulse; frozen at zero while not running.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick_en
);

  localparam int unsigned    CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  // Free-running modulo counter, held at zero outside RUN.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick_en = !rst && run && (count_q == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer, alarm and display mux in front of digital_clock.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned ALARM_TICKS = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             alarm_arm,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  output logic             tick_en,
  output logic             load,
  output logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] load_min,
  output logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] disp_min,
  output logic [HR_W-1:0]  disp_hr,
  output logic [2:0]       mode,
  output logic             alarm_out
);

  localparam int unsigned   AW      = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [AW-1:0] AL_LAST = AW'(ALARM_TICKS - 1);

  state_e           state_q;
  logic             mode_q, inc_q;
  logic             mode_edge, inc_edge;
  logic [HR_W-1:0]  shadow_hr_q, al_hr_q, load_hr_q;
  logic [MIN_W-1:0] shadow_min_q, al_min_q, load_min_q;
  logic             load_q;
  logic             alarm_q, match_q, match_d, alarm_clr;
  logic [AW-1:0]    alarm_cnt_q;
  logic             run;

  assign run = (state_q == RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .tick_en (tick_en)
  );

  // Button history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc  & ~inc_q;

  // Setting FSM: mode edge advances, inc edge bumps the field being edited.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      shadow_hr_q  <= '0;
      shadow_min_q <= '0;
      al_hr_q      <= '0;
      al_min_q     <= '0;
      load_q       <= 1'b0;
      load_hr_q    <= '0;
      load_min_q   <= '0;
    end else begin
      load_q <= 1'b0;
      if (mode_edge) begin
        case (state_q)
          RUN: begin
            state_q      <= SET_HR;
            shadow_hr_q  <= cur_hr;
            shadow_min_q <= cur_min;
          end
          SET_HR:    state_q <= SET_MIN;
          SET_MIN: begin
            state_q    <= SET_AL_HR;
            load_q     <= 1'b1;
            load_hr_q  <= shadow_hr_q;
            load_min_q <= shadow_min_q;
          end
          SET_AL_HR:  state_q <= SET_AL_MIN;
          SET_AL_MIN: state_q <= RUN;
          default:    state_q <= RUN;
        endcase
      end else if (inc_edge) begin
        case (state_q)
          SET_HR:     shadow_hr_q  <= hr_inc(shadow_hr_q);
          SET_MIN:    shadow_min_q <= min_inc(shadow_min_q);
          SET_AL_HR:  al_hr_q      <= hr_inc(al_hr_q);
          SET_AL_MIN: al_min_q     <= min_inc(al_min_q);
          default:    ;
        endcase
      end
    end
  end

  assign match_d   = run && alarm_arm && (cur_hr == al_hr_q) &&
                     (cur_min == al_min_q) && (cur_sec == '0);
  assign alarm_clr = mode_edge || inc_edge || !alarm_arm || !run;

  // Alarm: set on a fresh match, runs for ALARM_TICKS ticks, any clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
      match_q     <= 1'b0;
    end else begin
      match_q <= match_d;
      if (alarm_clr) begin
        alarm_q <= 1'b0;
      end else if (match_d && !match_q) begin
        alarm_q     <= 1'b1;
        alarm_cnt_q <= '0;
      end else if (alarm_q && tick_en) begin
        if (alarm_cnt_q == AL_LAST) begin
          alarm_q <= 1'b0;
        end else begin
          alarm_cnt_q <= alarm_cnt_q + 1'b1;
        end
      end
    end
  end

  // Display source follows the field being viewed or edited.
  always_comb begin
    disp_hr  = cur_hr;
    disp_min = cur_min;
    case (state_q)
      SET_HR, SET_MIN: begin
        disp_hr  = shadow_hr_q;
        disp_min = shadow_min_q;
      end
      SET_AL_HR, SET_AL_MIN: begin
        disp_hr  = al_hr_q;
        disp_min = al_min_q;
      end
      default: ;
    endcase
  end

  assign load      = load_q;
  assign load_hr   = load_hr_q;
  assign load_min  = load_min_q;
  assign load_sec  = '0;
  assign mode      = state_q;
  assign alarm_out = alarm_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=4, ALARM_TICKS=30.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_inc, alarm_arm;
  logic [6:0] cur_sec, cur_min;
  logic [4:0] cur_hr;
  logic       tick_en, load, alarm_out;
  logic [6:0] load_sec, load_min, disp_min;
  logic [4:0] load_hr, disp_hr;
  logic [2:0] mode;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned tick_seen = 0;
  int unsigned load_seen = 0;
  int unsigned cap_hr = 0, cap_min = 0, cap_sec = 99;

  always #5 clk = ~clk;

  clock_set_ctrl #(.TICK_DIV(4), .ALARM_TICKS(30)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_arm(alarm_arm), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
    .tick_en(tick_en), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hr(load_hr), .disp_min(disp_min), .disp_hr(disp_hr), .mode(mode),
    .alarm_out(alarm_out)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (tick_en) tick_seen++;
      if (load) begin
        load_seen++;
        cap_hr  = load_hr;
        cap_min = load_min;
        cap_sec = load_sec;
      end
    end
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step();
    btn_inc = 1'b0; step();
  endtask

  initial begin
    int unsigned mask;
    int unsigned first;
    int unsigned n;
    bit          done;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; alarm_arm = 1'b0;
    cur_sec = 7'd0; cur_min = 7'd0; cur_hr = 5'd0;
    repeat (3) step();
    chk("rst_tick", tick_en, 0);
    chk("rst_load", load, 0);
    chk("rst_alarm", alarm_out, 0);
    chk("rst_mode", mode, 0);
    chk("rst_load_hr", load_hr, 0);
    chk("rst_load_min", load_min, 0);
    chk("rst_load_sec", load_sec, 0);

    // Tick cadence after release: cycles 4, 8, 12.
    rst = 1'b0;
    mask = 0;
    for (int unsigned c = 1; c <= 12; c++) begin
      if (tick_en) mask |= (1 << (c - 1));
      step();
    end
    chk("tick_cadence", mask, 32'h888);

    // Wrap and simultaneous-button cases, then reset mid-set.
    cur_hr = 5'd23; cur_min = 7'd59; cur_sec = 7'd5;
    press_mode();
    chk("wrap_mode_sethr", mode, 1);
    chk("wrap_disp_hr23", disp_hr, 23);
    press_inc();
    chk("wrap_hr_0", disp_hr, 0);
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    chk("simul_mode", mode, 2);
    chk("simul_hr_kept", disp_hr, 0);
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    chk("wrap_disp_min59", disp_min, 59);
    press_inc();
    chk("wrap_min_0", disp_min, 0);
    load_seen = 0;
    rst = 1'b1; step();
    rst = 1'b0;
    chk("midrst_mode", mode, 0);
    chk("midrst_load_hr", load_hr, 0);
    first = 0;
    for (int unsigned c = 1; c <= 10; c++) begin
      if (tick_en) begin first = c; break; end
      step();
    end
    chk("midrst_first_tick", first, 4);
    chk("midrst_no_load", load_seen, 0);

    // Full set sequence from 13:45.
    cur_hr = 5'd13; cur_min = 7'd45; cur_sec = 7'd10;
    press_mode();
    tick_seen = 0;
    chk("set_mode1", mode, 1);
    chk("set_disp_hr13", disp_hr, 13);
    chk("set_disp_min45", disp_min, 45);
    repeat (3) press_inc();
    chk("set_hr16", disp_hr, 16);
    press_mode();
    chk("set_mode2", mode, 2);
    repeat (20) press_inc();
    chk("set_min5", disp_min, 5);
    load_seen = 0;
    press_mode();
    chk("load_count", load_seen, 1);
    chk("load_hr_val", cap_hr, 16);
    chk("load_min_val", cap_min, 5);
    chk("load_sec_val", cap_sec, 0);
    chk("load_pulse_done", load, 0);
    chk("set_mode3", mode, 3);
    chk("load_hr_held", load_hr, 16);
    chk("al_disp_hr0", disp_hr, 0);
    repeat (7) press_inc();
    chk("al_hr7", disp_hr, 7);
    press_mode();
    chk("set_mode4", mode, 4);
    repeat (30) press_inc();
    chk("al_min30", disp_min, 30);
    press_mode();
    chk("back_run", mode, 0);
    chk("no_tick_in_set", tick_seen, 0);
    chk("run_disp_hr", disp_hr, 13);
    chk("run_disp_min", disp_min, 45);

    // Alarm at 07:30:00 runs for 30 ticks.
    alarm_arm = 1'b1;
    cur_hr = 5'd7; cur_min = 7'd30; cur_sec = 7'd0;
    chk("alarm_pre", alarm_out, 0);
    step();
    chk("alarm_set", alarm_out, 1);
    n = 0; done = 1'b0;
    for (int unsigned c = 0; c < 200; c++) begin
      if (tick_en) n++;
      step();
      if (!alarm_out) begin done = 1'b1; break; end
    end
    chk("alarm_fell", done, 1);
    chk("alarm_ticks", n, 30);
    repeat (6) step();
    chk("alarm_no_retrig", alarm_out, 0);

    // Fresh match, then inc edge clears.
    cur_sec = 7'd1; step();
    cur_sec = 7'd0; step();
    chk("alarm_reset2", alarm_out, 1);
    repeat (3) step();
    btn_inc = 1'b1; step();
    chk("alarm_inc_clr", alarm_out, 0);
    chk("inc_run_mode", mode, 0);
    btn_inc = 1'b0; step();
    step();
    chk("alarm_stay_clr", alarm_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller for the digital_clock datapath (sec[6:0], min[6:0], hr[4:0], 24-hour). Generates the 1 Hz advance enable, sequences time-setting from two debounced pushbuttons, and loads new hr/min into the clock. Holds a programmable alarm and drives the display mux. Sits between the button debouncers and the digital_clock instance; digital_clock consumes tick_en and load/load_*.

Parameters:
TICK_DIV, 50_000_000, clk cycles per second tick (≥2); sim uses 4.
ALARM_TICKS, 30, tick_en pulses for which alarm_out stays high.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_mode  in  1  debounced, clk-synchronous mode button (level)
btn_inc  in  1  debounced, clk-synchronous increment button (level)
alarm_arm  in  1  alarm enable
cur_sec  in  7  digital_clock sec
cur_min  in  7  digital_clock min
cur_hr  in  5  digital_clock hr
tick_en  out  1  one-cycle advance pulse to digital_clock
load  out  1  one-cycle load strobe to digital_clock
load_sec  out  7  value loaded to sec (always 0)
load_min  out  7  value loaded to min
load_hr  out  5  value loaded to hr
disp_min  out  7  minutes to display
disp_hr  out  5  hours to display
mode  out  3  current state encoding
alarm_out  out  1  alarm active

Behaviour:
- Reset (sync, rst=1 at posedge): state=RUN, prescaler=0, shadow_hr/min=0, al_hr/al_min=0, btn regs=0, alarm_cnt=0; tick_en=0, load=0, load_*=0, alarm_out=0. Reset mid-set discards shadow values; no load issued.
- Edge detect: btn_q registers; mode_edge = btn_mode & ~mode_q, inc_edge likewise. Effects are visible on outputs after the clock edge at which the button is first sampled high. A held button produces one edge only.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. tick_en=1 for exactly one cycle when count==TICK_DIV-1. In any SET state, count is held at 0 and tick_en=0 (clock frozen). On return to RUN, the first tick_en comes TICK_DIV cycles later.
- FSM (advances on mode_edge):
  - RUN(0) -> SET_HR(1): shadow_hr<=cur_hr, shadow_min<=cur_min.
  - SET_HR -> SET_MIN(2).
  - SET_MIN -> SET_AL_HR(3): registered load=1 for one cycle; load_hr=shadow_hr, load_min=shadow_min, load_sec=0.
  - SET_AL_HR -> SET_AL_MIN(4).
  - SET_AL_MIN -> RUN.
- inc_edge:
  - SET_HR: shadow_hr+1, wraps 23->0.
  - SET_MIN: shadow_min+1, wraps 59->0.
  - SET_AL_HR: al_hr+1, wraps 23->0.
  - SET_AL_MIN: al_min+1, wraps 59->0.
  - RUN: inc_edge only clears the alarm (see below).
- Simultaneous mode_edge and inc_edge: mode wins; the increment is dropped.
- Display (combinational):
  - RUN: cur_hr/cur_min.
  - SET_HR/SET_MIN: shadow.
  - SET_AL_*: al_hr/al_min.
- Alarm:
  - Set: in RUN with alarm_arm=1 and cur_hr==al_hr, cur_min==al_min, cur_sec==0, alarm_out<=1 and alarm_cnt<=0 (registered, one cycle after the match).
  - Count: while alarm_out=1, each tick_en increments alarm_cnt. alarm_out clears when alarm_cnt reaches ALARM_TICKS-1 and tick_en=1.
  - Other clears: any button edge, alarm_arm=0, or leaving RUN. A clear takes priority over a set in the same cycle.
  - A re-match during the same second does not retrigger after a clear; the set condition additionally requires the sec==0 match to be new (match_q=0).
- Widths: compares are unsigned; load_sec is hard-wired to 7'd0.

Decomposition:
- clock_ctrl_pkg: state encoding (RUN..SET_AL_MIN, 3 bits), MAX_HR=23, MAX_MIN=59, SEC_W=7, MIN_W=7, HR_W=5.
- Sub-module tick_prescaler (clk, rst, run, tick_en), parameter TICK_DIV.
- Everything else (FSM, shadow/alarm regs, edge detect, display mux) lives in clock_set_ctrl.

Test Plan:
- Reset then RUN, TICK_DIV=4 -> tick_en pulses on cycles 4, 8, 12 after rst release; outputs 0 during rst.
- cur=13:45:xx, mode edge, 3 inc edges, mode, 20 inc edges, mode -> one load pulse with load_hr=16, load_min=5 (45+20 wraps), load_sec=0; no tick_en while in SET states.
- SET_HR at shadow_hr=23, inc -> 0; SET_MIN at 59, inc -> 0.
- btn_mode and btn_inc rising in the same cycle in SET_HR -> state=SET_MIN, shadow_hr unchanged.
- rst asserted in SET_MIN -> state=RUN, load never pulses, shadow=0, tick_en resumes after 4 cycles.
- Alarm set to 07:30, alarm_arm=1, drive cur=07:30:00 -> alarm_out=1 next cycle. Stays high through 29 tick_en pulses and falls on the 30th. Separately, an inc edge mid-alarm clears alarm_out the next cycle.
